// File: rtl/uncache_data_bridge.sv
`timescale 1ns/1ps
// Turns uncached CPU data-SRAM accesses into sram-like bus transactions and stalls the pipeline meanwhile.
// Optional: define UNCACHE_WBUF_EN to post uncached writes, which releases the pipeline at address accept.
module uncache_data_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        no_cache,
    input  logic        longest_stall,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_e;

    state_e      state_q;
    logic        data_req_q;
    logic        data_wr_q;
    logic [1:0]  data_size_q;
    logic [1:0]  data_size_d;
    logic [31:0] data_addr_q;
    logic [31:0] data_wdata_q;
    logic [31:0] rdata_q;
    logic        wr_pending_q;
    logic        uc_access;
    logic        issue;

    function automatic logic [1:0] size_of(input logic [3:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 2'd0;
            4'b0011, 4'b1100:                   size_of = 2'd1;
            default:                            size_of = 2'd2;
        endcase
    endfunction

    assign uc_access   = data_sram_en && no_cache;
    assign data_size_d = size_of(data_sram_wen);
    // A data_ok retiring the posted write frees the bus in the very cycle it arrives.
    assign issue       = uc_access && (!wr_pending_q || data_data_ok);

`ifdef UNCACHE_WBUF_EN
    localparam bit POSTED_WR = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pending_q <= 1'b0;
        end else if (state_q == REQ) begin
            if (data_addr_ok && data_wr_q) wr_pending_q <= 1'b1;
        end else if (data_data_ok) begin
            wr_pending_q <= 1'b0;
        end
    end
`else
    localparam bit POSTED_WR = 1'b0;

    assign wr_pending_q = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= 2'd0;
            data_addr_q  <= 32'd0;
            data_wdata_q <= 32'd0;
            rdata_q      <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q      <= REQ;
                        data_req_q   <= 1'b1;
                        data_wr_q    <= |data_sram_wen;
                        data_size_q  <= data_size_d;
                        data_addr_q  <= data_sram_addr;
                        data_wdata_q <= data_sram_wdata;
                    end
                end
                REQ: begin
                    // data_ok is not looked at here; the bus must accept the address first.
                    if (data_addr_ok) begin
                        data_req_q <= 1'b0;
                        state_q    <= (data_wr_q && POSTED_WR) ? HOLD : RESP;
                    end
                end
                RESP: begin
                    if (data_data_ok) begin
                        if (!data_wr_q) rdata_q <= data_rdata;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!longest_stall) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign d_stall         = uc_access && (state_q != HOLD);
    assign data_req        = data_req_q;
    assign data_wr         = data_wr_q;
    assign data_size       = data_size_q;
    assign data_addr       = data_addr_q;
    assign data_wdata      = data_wdata_q;
    assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_uncache_data_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for uncache_data_bridge: directed accesses push expected bus requests and load
// results into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_uncache_data_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'd0;
    logic [31:0] data_sram_addr = 32'd0;
    logic [31:0] data_sram_wdata = 32'd0;
    logic        no_cache = 1'b1;
    logic        longest_stall = 1'b0;
    logic [31:0] data_sram_rdata;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;

    uncache_data_bridge dut (
        .clk(clk), .rst(rst),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .no_cache(no_cache), .longest_stall(longest_stall),
        .data_sram_rdata(data_sram_rdata), .d_stall(d_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wr_stall(input int aok, input int dok);
`ifdef UNCACHE_WBUF_EN
        return aok + 2;
`else
        return aok + dok + 3;
`endif
    endfunction

    // Bus responder: automatic mode answers with programmed delays; manual mode replays man_* values.
    int          bus_aok = 0;
    int          bus_dok = 0;
    logic [31:0] bus_rdata = 32'd0;
    bit          bus_manual = 1'b0;
    logic        man_aok = 1'b0;
    logic        man_dok = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    int          bphase = 0;
    int          bcnt = 0;
    int          cur_dok = 0;
    logic [31:0] cur_rdata = 32'd0;

    initial forever begin
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (bus_manual) begin
            bphase       = 0;
            bcnt         = 0;
            data_addr_ok = man_aok;
            data_data_ok = man_dok;
            data_rdata   = man_rdata;
        end else if (rst) begin
            bphase = 0;
            bcnt   = 0;
        end else if (bphase == 0) begin
            if (data_req) begin
                if (bcnt >= bus_aok) begin
                    data_addr_ok = 1'b1;
                    cur_dok      = bus_dok;
                    cur_rdata    = bus_rdata;
                    bphase       = 1;
                    bcnt         = 0;
                end else begin
                    bcnt++;
                end
            end
        end else begin
            if (bcnt >= cur_dok) begin
                data_data_ok = 1'b1;
                data_rdata   = cur_rdata;
                bphase       = 0;
                bcnt         = 0;
            end else begin
                bcnt++;
            end
        end
    end

    // Monitor: request fields against the queue head while data_req is high, load data at stall release.
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        req_t r;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (data_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", {31'd0, data_req}, 32'd0);
                end else begin
                    r = req_q[0];
                    check("req_addr", data_addr, r.addr);
                    check("req_wr", {31'd0, data_wr}, {31'd0, r.wr});
                    check("req_size", {30'd0, data_size}, {30'd0, r.size});
                    if (r.wr) check("req_wdata", data_wdata, r.wdata);
                    if (data_addr_ok) void'(req_q.pop_front());
                end
            end
            if (bphase == 1 && !data_addr_ok)
                check("req_while_outstanding", {31'd0, data_req}, 32'd0);
            if (data_sram_en && no_cache && data_sram_wen == 4'd0 && !d_stall && prev_stall) begin
                if (rd_q.size() == 0) check("unexpected_load", {31'd0, d_stall}, 32'd1);
                else check("load_rdata", data_sram_rdata, rd_q.pop_front());
            end
            prev_stall = d_stall;
        end
    end

    task automatic idle(input int n);
        data_sram_en = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One uncached access from issue through HOLD; checks stall length, HOLD behaviour, return to IDLE.
    task automatic uc_access(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                             input logic [1:0] exp_size, input logic [31:0] rd, input int aok,
                             input int dok, input int ls, input int exp_stall);
        req_t r;
        int   cyc;
        r.addr = addr; r.wr = |wen; r.size = exp_size; r.wdata = wdata;
        req_q.push_back(r);
        if (wen == 4'd0) rd_q.push_back(rd);
        bus_aok = aok; bus_dok = dok; bus_rdata = rd;
        data_sram_en = 1'b1; no_cache = 1'b1; data_sram_wen = wen;
        data_sram_addr = addr; data_sram_wdata = wdata; longest_stall = (ls > 0);
        cyc = 0;
        @(negedge clk);
        while (d_stall && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("stall_cycles", cyc, exp_stall);
        for (int k = 1; k < ls; k++) begin
            @(negedge clk);
            check("hold_stall", {31'd0, d_stall}, 32'd0);
            check("hold_req", {31'd0, data_req}, 32'd0);
            if (wen == 4'd0) check("hold_rdata", data_sram_rdata, rd);
        end
        if (ls > 0) begin
            @(posedge clk);
            #1 longest_stall = 1'b0;
            @(negedge clk);
            check("hold_release_stall", {31'd0, d_stall}, 32'd0);
        end
        @(posedge clk);
        #1 check("idle_after_hold", {31'd0, d_stall}, 32'd1);
        data_sram_en = 1'b0;
        #1;
    endtask

    logic [3:0] tw_wen [6] = '{4'b0001, 4'b0100, 4'b0011, 4'b0110, 4'b1111, 4'b1000};
    logic [1:0] tw_size[6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0};

    initial begin
        // NOTE: bench drives inputs with blocking assignments just after the edge, so the DUT sees them settled.
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, data_req}, 32'd0);
        check("rst_wr", {31'd0, data_wr}, 32'd0);
        check("rst_size", {30'd0, data_size}, 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_wdata", data_wdata, 32'd0);
        check("rst_rdata", data_sram_rdata, 32'd0);
        check("rst_stall_idle", {31'd0, d_stall}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Minimum-latency read.
        uc_access(32'h1faf_f010, 4'b0000, 32'h0, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, 3);
        check("read_rdata_kept", data_sram_rdata, 32'hDEAD_BEEF);

        // Half-word write with slow address accept.
        uc_access(32'h1faf_f020, 4'b1100, 32'h1234_0000, 2'd1, 32'h0, 3, 1, 0, wr_stall(3, 1));
        idle(6);

        for (int i = 0; i < 6; i++) begin
            uc_access(32'h1faf_f030 + i, tw_wen[i], 32'hA5_0000 + i, tw_size[i], 32'h0, 0, 0, 0, wr_stall(0, 0));
            idle(4);
        end
        uc_access(32'h1faf_f038, 4'b0000, 32'h0, 2'd2, 32'h0BAD_CAFE, 1, 2, 0, 6);

        // Long HOLD under external stall.
        uc_access(32'h1faf_f03c, 4'b0000, 32'h0, 2'd2, 32'hA5A5_5A5A, 1, 1, 4, 5);
        idle(2);

        // Write immediately followed by read; write data_ok is slow.
        uc_access(32'h1faf_f040, 4'b1111, 32'hCAFE_F00D, 2'd2, 32'h0, 0, 5, 0, wr_stall(0, 5));
`ifdef UNCACHE_WBUF_EN
        uc_access(32'h1faf_f044, 4'b0000, 32'h0, 2'd2, 32'h1357_9BDF, 0, 0, 0, 7);
`else
        uc_access(32'h1faf_f044, 4'b0000, 32'h0, 2'd2, 32'h1357_9BDF, 0, 0, 0, 3);
`endif
        idle(3);

        // Cached accesses are ignored.
        data_sram_en = 1'b1; no_cache = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'h8000_0000;
        repeat (6) begin
            @(negedge clk);
            check("cached_stall", {31'd0, d_stall}, 32'd0);
            check("cached_req", {31'd0, data_req}, 32'd0);
        end
        @(posedge clk);
        #2 data_sram_en = 1'b0; no_cache = 1'b1;
        idle(2);

        // data_ok arriving in REQ must be ignored.
        begin
            req_t r;
            r.addr = 32'h1faf_f048; r.wr = 1'b0; r.size = 2'd2; r.wdata = 32'h0;
            req_q.push_back(r);
            rd_q.push_back(32'h600D_F00D);
            bus_manual = 1'b1; man_aok = 1'b0; man_dok = 1'b0;
            data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h1faf_f048;
            @(negedge clk); man_dok = 1'b1; man_rdata = 32'hBAD0_BAD0;
            @(negedge clk); man_dok = 1'b0; man_aok = 1'b1;
            @(negedge clk); man_aok = 1'b0; man_dok = 1'b1; man_rdata = 32'h600D_F00D;
            @(negedge clk); man_dok = 1'b0;
            check("early_dok_still_stalled", {31'd0, d_stall}, 32'd1);
            @(negedge clk);
            check("early_dok_hold", {31'd0, d_stall}, 32'd0);
            @(posedge clk);
            #2 data_sram_en = 1'b0;
        end
        idle(2);

        // Reset in RESP abandons the read.
        begin
            req_t r;
            r.addr = 32'h1faf_f050; r.wr = 1'b0; r.size = 2'd2; r.wdata = 32'h0;
            req_q.push_back(r);
            data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h1faf_f050;
            @(negedge clk); man_aok = 1'b1;
            @(negedge clk); man_aok = 1'b0;
            @(negedge clk);
            check("resp_req_low", {31'd0, data_req}, 32'd0);
            #1 rst = 1'b1;
            #1;
            check("midrst_req", {31'd0, data_req}, 32'd0);
            check("midrst_rdata", data_sram_rdata, 32'd0);
            check("midrst_addr", data_addr, 32'd0);
            check("midrst_stall_idle", {31'd0, d_stall}, 32'd1);
            @(posedge clk);
            #1 rst = 1'b0; data_sram_en = 1'b0;
            @(negedge clk); man_dok = 1'b1; man_rdata = 32'h5555_AAAA;
            @(negedge clk); man_dok = 1'b0;
            @(negedge clk);
            check("late_dok_rdata", data_sram_rdata, 32'd0);
            check("late_dok_req", {31'd0, data_req}, 32'd0);
            bus_manual = 1'b0;
        end
        idle(2);

        uc_access(32'h1faf_f054, 4'b0000, 32'h0, 2'd2, 32'h2468_ACE0, 0, 0, 0, 3);
        idle(3);
        check("req_queue_empty", req_q.size(), 32'd0);
        check("load_queue_empty", rd_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
